store_narrower: RTL and testbench
=================================

Name: store_narrower

Overview:
- Store-side counterpart of the load-path sign/zero extender.
- Takes a register-width store value (byte, halfword or word) and narrows and lane-aligns it onto a narrower little-endian memory write bus.
- Wide stores are split into successive bus beats with a valid/ready handshake.
- Sits between the execute-stage store request and the data-memory write port.

Parameters:
- INPUT_WIDTH, 32, width of the store data from the register file; only 32 is supported.
- BUS_WIDTH, 16, width of the memory write data bus; 16 or 32.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- reqValid  input  1  store request present.
- reqReady  output  1  block can accept a request.
- reqAddr  input  ADDR_WIDTH  byte address of the store.
- reqData  input  INPUT_WIDTH  store value, right-justified.
- reqSize  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- busValid  output  1  write beat valid.
- busReady  input  1  memory accepts the beat.
- busAddr  output  ADDR_WIDTH  beat address, aligned to BUS_WIDTH/8.
- busData  output  BUS_WIDTH  lane-positioned write data.
- busByteEn  output  BUS_WIDTH/8  per-byte write enables.
- done  output  1  one-cycle pulse: store completed.
- misalignErr  output  1  one-cycle pulse: store rejected.

Behaviour:
- Reset (async, resetN=0):
  - State goes to IDLE.
  - reqReady=0 while resetN=0, then 1 in IDLE.
  - busValid, busAddr, busData, busByteEn, done and misalignErr all go to 0.
  - Any in-flight beats are discarded; no partial resume.
- States: IDLE, SEND, ERR.
- IDLE:
  - reqReady=1.
  - On reqValid&reqReady, capture addr, data and size.
  - If the request is misaligned or reqSize=3, go to ERR.
  - Otherwise load the beat counter and go to SEND.
  - Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- Request-to-first-beat latency: exactly 1 cycle (busValid high in the cycle after acceptance).
- SEND:
  - busValid=1. Payload is held stable until busValid&busReady.
  - On each handshake, advance to the next beat; next beat's busAddr = previous + BUS_WIDTH/8.
  - After the final beat's handshake, go to IDLE and pulse done=1 in that cycle.
  - reqReady=0 throughout SEND; a new request is accepted no earlier than the cycle after done.
- ERR: lasts one cycle. misalignErr=1, no bus beat issued, then return to IDLE.
- Beat count: max(1, size_bytes/(BUS_WIDTH/8)). Word on a 16-bit bus gives 2 beats, low half first.
- Lane placement:
  - busData byte lane k carries the store byte destined for address busAddr+k.
  - busByteEn bit k is set only for written lanes.
  - Non-enabled lanes drive 0.
  - Example: byte store at an address with offset 1 on a 16-bit bus puts reqData[7:0] on busData[15:8] with busByteEn=2'b10.
- busAddr = beat address with the low log2(BUS_WIDTH/8) bits cleared.
- No sign or zero handling is needed. Upper reqData bits beyond the store size are ignored.
- busReady held low indefinitely: the block waits with the payload stable, and no timeout is applied.
- busReady high in the same cycle busValid first rises: the beat completes in that cycle.
- reqValid while not in IDLE: ignored; the requester must hold its request.

Optional Feature:
- Macro: STORE_NARROWER_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned half/word stores are not rejected.
  - They are issued as size_bytes single-byte beats in ascending address order.
  - Each beat has one byte-enable bit set; byte i of reqData goes to address reqAddr+i.
  - done pulses after the last beat; misalignErr is driven only for reqSize=3.
- Undefined: misaligned stores take the ERR path as described in Behaviour.

Test Plan:
- BUS_WIDTH=16, word store at addr 0x100, data 0xDEADBEEF, busReady=1 → two beats: {0x100, 0xBEEF, 2'b11} then {0x102, 0xDEAD, 2'b11}; done on the second beat; first busValid 1 cycle after acceptance.
- Byte store at addr 0x205, data 0x123456A5 → one beat {0x204, 0xA500, 2'b10}, then done.
- Half store at addr 0x301 (macro off) → misalignErr pulse for 1 cycle, busValid never high, reqReady back to 1 the next cycle.
- Word store with busReady held 0 for 5 cycles → first beat payload unchanged across all stall cycles; completes 1 cycle after busReady=1.
- resetN pulled low while in SEND between beats → all outputs 0 immediately; after release, no second beat and no done.
- Macro on: word store at addr 0x403, data 0x11223344 → four byte beats {0x402, 0x4400, 2'b10}, {0x404, 0x0033, 2'b01}, {0x404, 0x2200, 2'b10}, {0x406, 0x0011, 2'b01}, then done.

Source files
------------

// File: rtl/store_narrower_if.sv
// Store request and memory write-beat signals for store_narrower.
// slave = the narrower itself, master = requester plus memory side.
interface store_narrower_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INPUT_WIDTH = 32,
  parameter int BUS_WIDTH   = 16
);
  logic                     reqValid;
  logic                     reqReady;
  logic [ADDR_WIDTH-1:0]    reqAddr;
  logic [INPUT_WIDTH-1:0]   reqData;
  logic [1:0]               reqSize;
  logic                     busValid;
  logic                     busReady;
  logic [ADDR_WIDTH-1:0]    busAddr;
  logic [BUS_WIDTH-1:0]     busData;
  logic [BUS_WIDTH/8-1:0]   busByteEn;
  logic                     done;
  logic                     misalignErr;

  modport master (
    output reqValid, reqAddr, reqData, reqSize, busReady,
    input  reqReady, busValid, busAddr, busData, busByteEn, done, misalignErr
  );
  modport slave (
    input  reqValid, reqAddr, reqData, reqSize, busReady,
    output reqReady, busValid, busAddr, busData, busByteEn, done, misalignErr
  );
endinterface

// File: rtl/store_narrower.sv
// Narrows a 32-bit store onto a little-endian write bus, splitting into beats.
// STORE_NARROWER_MISALIGN_SPLIT_EN: issue misaligned half/word stores as byte beats.
module store_narrower #(
  parameter int INPUT_WIDTH = 32,
  parameter int BUS_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic           clk,
  input  logic           resetN,
  store_narrower_if.slave sif
);
  localparam int BB   = BUS_WIDTH / 8;
  localparam int OFFW = $clog2(BB);

  typedef enum logic [1:0] {IDLE, SEND, ERR} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  cur_addr;    // byte address of the current beat's first byte
  logic [INPUT_WIDTH-1:0] data_q;      // remaining bytes, current beat right-justified
  logic [2:0]             nbytes;
  logic [2:0]             beats_left;
  logic [2:0]             size_bytes, acc_nbytes, acc_beats;
  logic                   misaligned, reject, hs, last;
  logic [OFFW-1:0]        off;
  logic [BUS_WIDTH-1:0]   dmask;
  logic [BB-1:0]          be_base;

  // request decode
  always_comb begin
    case (sif.reqSize)
      2'd1:    size_bytes = 3'd2;
      2'd2:    size_bytes = 3'd4;
      default: size_bytes = 3'd1;
    endcase
    misaligned = (sif.reqSize == 2'd1 && sif.reqAddr[0]) ||
                 (sif.reqSize == 2'd2 && sif.reqAddr[1:0] != 2'b00);
    acc_nbytes = (size_bytes > 3'(BB)) ? 3'(BB) : size_bytes;
    acc_beats  = (size_bytes > 3'(BB)) ? (size_bytes >> OFFW) : 3'd1;
`ifdef STORE_NARROWER_MISALIGN_SPLIT_EN
    reject = (sif.reqSize == 2'd3);
    if (misaligned) begin
      acc_nbytes = 3'd1;
      acc_beats  = size_bytes;
    end
`else
    reject = (sif.reqSize == 2'd3) || misaligned;
`endif
  end

  assign hs   = (state == SEND) && sif.busReady;
  assign last = (beats_left == 3'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    sif.reqReady    = 1'b0;
    sif.busValid    = 1'b0;
    sif.done        = 1'b0;
    sif.misalignErr = 1'b0;
    case (state)
      IDLE: begin
        sif.reqReady = resetN;
        if (sif.reqValid) state_nxt = reject ? ERR : SEND;
      end
      SEND: begin
        sif.busValid = 1'b1;
        if (sif.busReady && last) begin
          sif.done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        sif.misalignErr = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_addr   <= '0;
      data_q     <= '0;
      nbytes     <= '0;
      beats_left <= '0;
    end else if (state == IDLE && sif.reqValid) begin
      cur_addr   <= sif.reqAddr;
      data_q     <= sif.reqData;
      nbytes     <= acc_nbytes;
      beats_left <= acc_beats;
    end else if (hs) begin
      cur_addr   <= cur_addr + ADDR_WIDTH'(nbytes);
      data_q     <= data_q >> {nbytes, 3'b000};
      beats_left <= beats_left - 3'd1;
    end
  end

  // lane placement: low nbytes of data_q shifted up to the beat's byte offset
  always_comb begin
    off = cur_addr[OFFW-1:0];
    for (int k = 0; k < BB; k++) begin
      be_base[k]      = (k < int'(nbytes));
      dmask[k*8 +: 8] = {8{be_base[k]}};
    end
    sif.busAddr   = '0;
    sif.busData   = '0;
    sif.busByteEn = '0;
    if (state == SEND) begin
      sif.busAddr   = {cur_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
      sif.busData   = (data_q[BUS_WIDTH-1:0] & dmask) << {off, 3'b000};
      sif.busByteEn = be_base << off;
    end
  end
endmodule

// File: tb/tb_store_narrower.sv
// Directed-vector bench for store_narrower on a 16-bit bus.
module tb_store_narrower;
  logic clk;
  logic resetN;
  int   checks = 0;
  int   errors = 0;
  logic [51:0] obs, exp;

  store_narrower_if #(.ADDR_WIDTH(32), .INPUT_WIDTH(32), .BUS_WIDTH(16)) sif ();

  store_narrower #(.INPUT_WIDTH(32), .BUS_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk(clk), .resetN(resetN), .sif(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    sif.reqValid = 1'b1;
    sif.reqAddr  = a;
    sif.reqData  = d;
    sif.reqSize  = s;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    if ({obs, sif.reqReady, sif.misalignErr} !== 54'd0) begin
      errors++; $display("FAIL reset_outputs: got %h rdy=%b err=%b exp all 0", obs, sif.reqReady, sif.misalignErr);
    end
    @(negedge clk); resetN = 1'b1;
    @(negedge clk);
    checks++;
    if (sif.reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", sif.reqReady); end
  endtask

  task automatic test_word_store;
    @(negedge clk); drive_req(32'h100, 32'hDEADBEEF, 2'd2); sif.busReady = 1'b1;
    checks++;
    if (sif.reqReady !== 1'b1 || sif.busValid !== 1'b0) begin
      errors++; $display("FAIL word_accept: rdy=%b vld=%b exp 1 0", sif.reqReady, sif.busValid);
    end
    @(negedge clk); sif.reqValid = 1'b0;
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h100, 16'hBEEF, 2'b11, 1'b0};
    if (obs !== exp || sif.reqReady !== 1'b0) begin errors++; $display("FAIL word_beat0: got %h exp %h", obs, exp); end
    @(negedge clk);
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h102, 16'hDEAD, 2'b11, 1'b1};
    if (obs !== exp) begin errors++; $display("FAIL word_beat1: got %h exp %h", obs, exp); end
    @(negedge clk);
    checks++;
    if (sif.busValid !== 1'b0 || sif.done !== 1'b0 || sif.reqReady !== 1'b1) begin
      errors++; $display("FAIL word_idle: vld=%b done=%b rdy=%b exp 0 0 1", sif.busValid, sif.done, sif.reqReady);
    end
  endtask

  task automatic test_byte_store;
    @(negedge clk); drive_req(32'h205, 32'h123456A5, 2'd0); sif.busReady = 1'b1;
    @(negedge clk); sif.reqValid = 1'b0;
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h204, 16'hA500, 2'b10, 1'b1};
    if (obs !== exp) begin errors++; $display("FAIL byte_beat: got %h exp %h", obs, exp); end
    @(negedge clk);
    checks++;
    if (sif.busValid !== 1'b0 || sif.reqReady !== 1'b1) begin
      errors++; $display("FAIL byte_idle: vld=%b rdy=%b exp 0 1", sif.busValid, sif.reqReady);
    end
  endtask

  task automatic test_misalign;
`ifdef STORE_NARROWER_MISALIGN_SPLIT_EN
    logic [51:0] wexp [4];
    wexp[0] = {1'b1, 32'h402, 16'h4400, 2'b10, 1'b0};
    wexp[1] = {1'b1, 32'h404, 16'h0033, 2'b01, 1'b0};
    wexp[2] = {1'b1, 32'h404, 16'h2200, 2'b10, 1'b0};
    wexp[3] = {1'b1, 32'h406, 16'h0011, 2'b01, 1'b1};
    @(negedge clk); drive_req(32'h403, 32'h11223344, 2'd2); sif.busReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sif.reqValid = 1'b0;
      checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
      if (obs !== wexp[i] || sif.misalignErr !== 1'b0) begin
        errors++; $display("FAIL split_word_beat%0d: got %h exp %h", i, obs, wexp[i]);
      end
    end
    @(negedge clk); drive_req(32'h301, 32'h0000BEEF, 2'd1);
    @(negedge clk); sif.reqValid = 1'b0;
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h300, 16'hEF00, 2'b10, 1'b0};
    if (obs !== exp) begin errors++; $display("FAIL split_half_beat0: got %h exp %h", obs, exp); end
    @(negedge clk);
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h302, 16'h00BE, 2'b01, 1'b1};
    if (obs !== exp) begin errors++; $display("FAIL split_half_beat1: got %h exp %h", obs, exp); end
    @(negedge clk);
`else
    @(negedge clk); drive_req(32'h301, 32'h0000BEEF, 2'd1); sif.busReady = 1'b1;
    @(negedge clk); sif.reqValid = 1'b0;
    checks++;
    if (sif.misalignErr !== 1'b1 || sif.busValid !== 1'b0 || sif.reqReady !== 1'b0) begin
      errors++; $display("FAIL half_misalign_err: err=%b vld=%b rdy=%b exp 1 0 0", sif.misalignErr, sif.busValid, sif.reqReady);
    end
    @(negedge clk);
    checks++;
    if (sif.misalignErr !== 1'b0 || sif.busValid !== 1'b0 || sif.reqReady !== 1'b1) begin
      errors++; $display("FAIL half_misalign_after: err=%b vld=%b rdy=%b exp 0 0 1", sif.misalignErr, sif.busValid, sif.reqReady);
    end
    drive_req(32'h403, 32'h11223344, 2'd2);
    @(negedge clk); sif.reqValid = 1'b0;
    checks++;
    if (sif.misalignErr !== 1'b1 || sif.busValid !== 1'b0) begin
      errors++; $display("FAIL word_misalign_err: err=%b vld=%b exp 1 0", sif.misalignErr, sif.busValid);
    end
    @(negedge clk);
`endif
    // size 3 is rejected in both builds, even when aligned
    drive_req(32'h500, 32'h0, 2'd3);
    @(negedge clk); sif.reqValid = 1'b0;
    checks++;
    if (sif.misalignErr !== 1'b1 || sif.busValid !== 1'b0) begin
      errors++; $display("FAIL size3_err: err=%b vld=%b exp 1 0", sif.misalignErr, sif.busValid);
    end
    @(negedge clk);
  endtask

  task automatic test_stall;
    @(negedge clk); drive_req(32'h100, 32'hCAFEF00D, 2'd2); sif.busReady = 1'b0;
    @(negedge clk); sif.reqValid = 1'b0;
    exp = {1'b1, 32'h100, 16'hF00D, 2'b11, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
      if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d: got %h exp %h", i, obs, exp); end
      @(negedge clk);
    end
    sif.busReady = 1'b1;
    #1;
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    if (obs !== exp) begin errors++; $display("FAIL stall_release: got %h exp %h", obs, exp); end
    @(negedge clk);
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h102, 16'hCAFE, 2'b11, 1'b1};
    if (obs !== exp) begin errors++; $display("FAIL stall_beat1: got %h exp %h", obs, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_send;
    logic bad;
    @(negedge clk); drive_req(32'h600, 32'h87654321, 2'd2); sif.busReady = 1'b1;
    @(negedge clk); sif.reqValid = 1'b0;
    @(negedge clk);
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h602, 16'h8765, 2'b11, 1'b1};
    if (obs !== exp) begin errors++; $display("FAIL rst_pre_beat1: got %h exp %h", obs, exp); end
    sif.busReady = 1'b0;
    #1 resetN = 1'b0;
    #1;
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    if ({obs, sif.reqReady, sif.misalignErr} !== 54'd0) begin
      errors++; $display("FAIL rst_mid_zero: got %h rdy=%b exp all 0", obs, sif.reqReady);
    end
    @(negedge clk); resetN = 1'b1; sif.busReady = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (sif.busValid !== 1'b0 || sif.done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0 || sif.reqReady !== 1'b1) begin
      errors++; $display("FAIL rst_no_resume: stray beat/done=%b rdy=%b exp 0 1", bad, sif.reqReady);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); drive_req(32'h201, 32'h00000077, 2'd0); sif.busReady = 1'b1;
    @(negedge clk); drive_req(32'h302, 32'h00005566, 2'd1);
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h200, 16'h7700, 2'b10, 1'b1};
    if (obs !== exp || sif.reqReady !== 1'b0) begin errors++; $display("FAIL b2b_first: got %h exp %h", obs, exp); end
    @(negedge clk);
    checks++;
    if (sif.busValid !== 1'b0 || sif.reqReady !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: vld=%b rdy=%b exp 0 1", sif.busValid, sif.reqReady);
    end
    @(negedge clk); sif.reqValid = 1'b0;
    checks++; obs = {sif.busValid, sif.busAddr, sif.busData, sif.busByteEn, sif.done};
    exp = {1'b1, 32'h302, 16'h5566, 2'b11, 1'b1};
    if (obs !== exp) begin errors++; $display("FAIL b2b_second: got %h exp %h", obs, exp); end
    @(negedge clk);
  endtask

  initial begin
    resetN       = 1'b0;
    sif.reqValid = 1'b0;
    sif.reqAddr  = '0;
    sif.reqData  = '0;
    sif.reqSize  = '0;
    sif.busReady = 1'b0;
    test_reset();
    test_word_store();
    test_byte_store();
    test_misalign();
    test_stall();
    test_reset_mid_send();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
